// File: rtl/hqm_aw_tap_ctrl_pkg.sv
// hqm_aw_tap_ctrl_pkg: TAP state encodings, opcode constants and IR capture pattern
package hqm_aw_tap_ctrl_pkg;
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;
  localparam logic [7:0] TAP_OPC_BYPASS = 8'hFF;
  localparam logic [7:0] TAP_OPC_IDCODE = 8'h02;
  localparam logic [1:0] TAP_IR_CAPTURE = 2'b01;
endpackage

// File: rtl/hqm_aw_tap_ctrl_fsm.sv
// hqm_aw_tap_ctrl_fsm: 16-state IEEE 1149.1 TAP state machine driven by tms
module hqm_aw_tap_ctrl_fsm
  import hqm_aw_tap_ctrl_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trstb,
  input  logic       i_tms,
  output tap_state_t o_state
);
  tap_state_t r_state;
  // state register with the standard tms transition table
  always_ff @(posedge i_tck or negedge i_trstb)
    if (!i_trstb) r_state <= TLR;
    else
      case (r_state)
        TLR:      r_state <= i_tms ? TLR    : RTI;
        RTI:      r_state <= i_tms ? SEL_DR : RTI;
        SEL_DR:   r_state <= i_tms ? SEL_IR : CAP_DR;
        CAP_DR:   r_state <= i_tms ? EX1_DR : SH_DR;
        SH_DR:    r_state <= i_tms ? EX1_DR : SH_DR;
        EX1_DR:   r_state <= i_tms ? UPD_DR : PAUSE_DR;
        PAUSE_DR: r_state <= i_tms ? EX2_DR : PAUSE_DR;
        EX2_DR:   r_state <= i_tms ? UPD_DR : SH_DR;
        UPD_DR:   r_state <= i_tms ? SEL_DR : RTI;
        SEL_IR:   r_state <= i_tms ? TLR    : CAP_IR;
        CAP_IR:   r_state <= i_tms ? EX1_IR : SH_IR;
        SH_IR:    r_state <= i_tms ? EX1_IR : SH_IR;
        EX1_IR:   r_state <= i_tms ? UPD_IR : PAUSE_IR;
        PAUSE_IR: r_state <= i_tms ? EX2_IR : PAUSE_IR;
        EX2_IR:   r_state <= i_tms ? UPD_IR : SH_IR;
        UPD_IR:   r_state <= i_tms ? SEL_DR : RTI;
      endcase
  assign o_state = r_state;
endmodule

// File: rtl/hqm_aw_tap_ctrl.sv
// hqm_aw_tap_ctrl: TAP controller driving remote TDRs; HQM_AW_TAP_IDCODE_EN adds the IDCODE register
module hqm_aw_tap_ctrl
  import hqm_aw_tap_ctrl_pkg::*;
#(
  parameter int                 IRWIDTH       = 8,
  parameter int                 NUM_RTDR      = 4,
  parameter logic [IRWIDTH-1:0] RTDR_OPC_BASE = 8'h10,
  parameter logic [31:0]        IDCODE_VAL    = 32'h0000_0001
) (
  input  logic                tck,
  input  logic                trstb,
  input  logic                tms,
  input  logic                tdi,
  input  logic [NUM_RTDR-1:0] rtdr_tdo,
  output logic [NUM_RTDR-1:0] irdec,
  output logic                shiftdr,
  output logic                capturedr,
  output logic                updatedr,
  output logic                tdo,
  output logic                tdo_en
);
`ifdef HQM_AW_TAP_IDCODE_EN
  localparam logic [IRWIDTH-1:0] IR_RST = IRWIDTH'(TAP_OPC_IDCODE);
`else
  localparam logic [IRWIDTH-1:0] IR_RST = '1;
`endif
  tap_state_t         w_state;
  logic [IRWIDTH-1:0] r_ir_sh;
  logic [IRWIDTH-1:0] r_ir;
  logic               r_bypass;
  logic               w_dr_tdo;
  logic               w_tdo;
  hqm_aw_tap_ctrl_fsm u_fsm (
    .i_tck   (tck),
    .i_trstb (trstb),
    .i_tms   (tms),
    .o_state (w_state)
  );
  assign shiftdr   = w_state == SH_DR;
  assign capturedr = w_state == CAP_DR;
  assign updatedr  = w_state == UPD_DR;
  // one-hot RTDR select decoded from the active IR
  always_comb begin
    irdec = '0;
    for (int i = 0; i < NUM_RTDR; i++) irdec[i] = r_ir == RTDR_OPC_BASE + IRWIDTH'(i);
  end
  // IR shift stage: capture the fixed 01 pattern, then shift LSB-first toward tdo
  always_ff @(posedge tck or negedge trstb)
    if (!trstb) r_ir_sh <= '0;
    else if (w_state == CAP_IR) r_ir_sh <= IRWIDTH'(TAP_IR_CAPTURE);
    else if (w_state == SH_IR) r_ir_sh <= {tdi, r_ir_sh[IRWIDTH-1:1]};
  // one-bit BYPASS register
  always_ff @(posedge tck or negedge trstb)
    if (!trstb) r_bypass <= 1'b0;
    else if (capturedr) r_bypass <= 1'b0;
    else if (shiftdr) r_bypass <= tdi;
`ifdef HQM_AW_TAP_IDCODE_EN
  logic [31:0] r_idcode;
  // IDCODE register: capture the constant, shift LSB-first
  always_ff @(posedge tck or negedge trstb)
    if (!trstb) r_idcode <= '0;
    else if (capturedr) r_idcode <= IDCODE_VAL;
    else if (shiftdr) r_idcode <= {tdi, r_idcode[31:1]};
  assign w_dr_tdo = |irdec ? |(irdec & rtdr_tdo) :
                    r_ir == IRWIDTH'(TAP_OPC_IDCODE) ? r_idcode[0] : r_bypass;
`else
  logic w_unused_idcode;
  assign w_unused_idcode = ^IDCODE_VAL;
  assign w_dr_tdo = |irdec ? |(irdec & rtdr_tdo) : r_bypass;
`endif
  assign w_tdo = w_state == SH_IR ? r_ir_sh[0] : shiftdr ? w_dr_tdo : 1'b0;
  // falling-edge domain: active IR update and tdo launch
  always_ff @(negedge tck or negedge trstb)
    if (!trstb) begin
      r_ir   <= IR_RST;
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= w_tdo;
      tdo_en <= w_state == SH_IR || shiftdr;
      if (w_state == UPD_IR) r_ir <= r_ir_sh;
      else if (w_state == TLR) r_ir <= IR_RST;
    end
endmodule

// File: tb/tb_hqm_aw_tap_ctrl.sv
// tb_hqm_aw_tap_ctrl: directed self-checking bench for hqm_aw_tap_ctrl
module tb_hqm_aw_tap_ctrl;
  import hqm_aw_tap_ctrl_pkg::*;
  localparam logic [31:0] IDV = 32'h1234_5679;
  logic       tck = 1'b0;
  logic       trstb = 1'b1;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic [3:0] rtdr_tdo = 4'b0;
  logic [3:0] irdec;
  logic       shiftdr, capturedr, updatedr, tdo, tdo_en;
  int n_chk = 0;
  int n_fail = 0;
  int n_cap = 0, n_sh = 0, n_up = 0, n_ovl = 0;
  logic [7:0]  so;
  logic [31:0] dout, en;
  int c_cap, c_sh, c_up, c_ovl;

  hqm_aw_tap_ctrl #(
    .IRWIDTH       (8),
    .NUM_RTDR      (4),
    .RTDR_OPC_BASE (8'h10),
    .IDCODE_VAL    (IDV)
  ) dut (
    .tck       (tck),
    .trstb     (trstb),
    .tms       (tms),
    .tdi       (tdi),
    .rtdr_tdo  (rtdr_tdo),
    .irdec     (irdec),
    .shiftdr   (shiftdr),
    .capturedr (capturedr),
    .updatedr  (updatedr),
    .tdo       (tdo),
    .tdo_en    (tdo_en)
  );

  always #5 tck = ~tck;

  always @(negedge tck) begin
    n_cap <= n_cap + int'(capturedr);
    n_sh  <= n_sh + int'(shiftdr);
    n_up  <= n_up + int'(updatedr);
    n_ovl <= n_ovl + int'(int'(capturedr) + int'(shiftdr) + int'(updatedr) > 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #2;
  endtask

  task automatic load_ir(input logic [7:0] v, output logic [7:0] o);
    o = '0;
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      clk(k == 7, v[k]);
      o[k] = tdo;
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] di, input logic [31:0] rp,
                         output logic [31:0] o, output logic [31:0] e);
    o = '0;
    e = '0;
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    rtdr_tdo = {{3{~rp[0]}}, rp[0]};
    for (int k = 0; k < n; k++) begin
      clk(k == n - 1, di[k]);
      o[k] = tdo;
      e[k] = tdo_en;
      rtdr_tdo = (k + 1 < 32) ? {{3{~rp[k+1]}}, rp[k+1]} : 4'b0;
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    rtdr_tdo = 4'b0;
  endtask

  tap_state_t st_l[16] = '{TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR,
                           UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR};
  int len_l[16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  logic [6:0] pth_l[16] = '{7'b0000000, 7'b0000000, 7'b0000010, 7'b0000010,
                            7'b0000010, 7'b0001010, 7'b0001010, 7'b0101010,
                            7'b0011010, 7'b0000110, 7'b0000110, 7'b0000110,
                            7'b0010110, 7'b0010110, 7'b1010110, 7'b0110110};

  initial begin
    #1 trstb = 1'b0;
    #1;
    chk("rst_state", 32'(dut.w_state), 32'(TLR));
    chk("rst_tdo", 32'(tdo), 32'(1'b0));
    chk("rst_tdo_en", 32'(tdo_en), 32'(1'b0));
    chk("rst_irdec", 32'(irdec), 32'(4'b0));
    chk("rst_strobes", 32'({capturedr, shiftdr, updatedr}), 32'(3'b0));
    #10 trstb = 1'b1;
    clk(1'b1, 1'b0);
    chk("tlr_hold", 32'(dut.w_state), 32'(TLR));
    clk(1'b0, 1'b0);
    chk("to_rti", 32'(dut.w_state), 32'(RTI));
    load_ir(8'h11, so);
    chk("ir_capture_1", 32'(so), 32'(8'h01));
    chk("irdec_11", 32'(irdec), 32'(4'b0010));
    load_ir(8'h10, so);
    chk("ir_capture_2", 32'(so), 32'(8'h01));
    chk("irdec_10", 32'(irdec), 32'(4'b0001));
    chk("tdo_en_idle", 32'(tdo_en), 32'(1'b0));
    c_cap = n_cap; c_sh = n_sh; c_up = n_up; c_ovl = n_ovl;
    scan_dr(16, 32'h0000_3C5A, 32'h0000_A5C3, dout, en);
    chk("rtdr_tdo", 32'(dout[15:0]), 32'(16'hA5C3));
    chk("rtdr_tdo_en", 32'(en[15:0]), 32'(16'hFFFF));
    chk("capturedr_cnt", 32'(n_cap - c_cap), 32'd1);
    chk("shiftdr_cnt", 32'(n_sh - c_sh), 32'd16);
    chk("updatedr_cnt", 32'(n_up - c_up), 32'd1);
    chk("strobe_overlap", 32'(n_ovl - c_ovl), 32'd0);
    chk("irdec_stable", 32'(irdec), 32'(4'b0001));
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    chk("cap_strobe", 32'({capturedr, shiftdr, updatedr}), 32'(3'b100));
    clk(1'b0, 1'b0);
    chk("sh_strobe", 32'({capturedr, shiftdr, updatedr}), 32'(3'b010));
    clk(1'b1, 1'b0);
    chk("ex1_no_shift", 32'(shiftdr), 32'(1'b0));
    clk(1'b0, 1'b0);
    chk("pause_no_shift", 32'(shiftdr), 32'(1'b0));
    chk("pause_state", 32'(dut.w_state), 32'(PAUSE_DR));
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    chk("resume_shift", 32'(shiftdr), 32'(1'b1));
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    chk("upd_strobe", 32'({capturedr, shiftdr, updatedr}), 32'(3'b001));
    clk(1'b0, 1'b0);
    load_ir(8'hFF, so);
    chk("irdec_ff", 32'(irdec), 32'(4'b0));
    scan_dr(4, 32'b1101, 32'hFFFF_FFFF, dout, en);
    chk("bypass_ff", 32'(dout[3:0]), 32'(4'b1010));
    load_ir(8'h3C, so);
    chk("irdec_3c", 32'(irdec), 32'(4'b0));
    scan_dr(4, 32'b1101, 32'hFFFF_FFFF, dout, en);
    chk("bypass_3c", 32'(dout[3:0]), 32'(4'b1010));
    repeat (5) clk(1'b1, 1'b0);
    chk("tlr_from_rti", 32'(dut.w_state), 32'(TLR));
    for (int s = 0; s < 16; s++) begin
      for (int j = 0; j < len_l[s]; j++) clk(pth_l[s][j], 1'b0);
      chk($sformatf("reach_%0d", s), 32'(dut.w_state), 32'(st_l[s]));
      repeat (5) clk(1'b1, 1'b0);
      chk($sformatf("recover_%0d", s), 32'(dut.w_state), 32'(TLR));
    end
    clk(1'b0, 1'b0);
    load_ir(8'h10, so);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    rtdr_tdo = 4'b0001;
    clk(1'b0, 1'b1);
    chk("pre_rst_tdo", 32'(tdo), 32'(1'b1));
    chk("pre_rst_tdo_en", 32'(tdo_en), 32'(1'b1));
    trstb = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dut.w_state), 32'(TLR));
    chk("mid_rst_tdo", 32'(tdo), 32'(1'b0));
    chk("mid_rst_tdo_en", 32'(tdo_en), 32'(1'b0));
    chk("mid_rst_irdec", 32'(irdec), 32'(4'b0));
    chk("mid_rst_shiftdr", 32'(shiftdr), 32'(1'b0));
    #1 trstb = 1'b1;
    rtdr_tdo = 4'b0;
    clk(1'b0, 1'b0);
    chk("post_rst_rti", 32'(dut.w_state), 32'(RTI));
    scan_dr(32, 32'hDEAD_BEEF, 32'h0, dout, en);
`ifdef HQM_AW_TAP_IDCODE_EN
    chk("idcode_scan", dout, IDV);
`else
    chk("idcode_scan", dout, {32'hDEAD_BEEF << 1});
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
